// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// Optional occupancy counter is enabled with the PIPE_REG_COUNT_EN macro.
package pipe_reg_pkg;

   localparam int PIPE_WIDTH_DEFAULT  = 2;
   localparam int PIPE_STAGES_DEFAULT = 2;

   // Layout template for a stage word: flag sits above the data bits.
   typedef struct packed {
      logic                          flag;
      logic [PIPE_WIDTH_DEFAULT-1:0] data;
   } pipe_word_t;

   function automatic int cnt_w(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic stage: valid bit plus {flag,data} word with hold/load select.
// Flush clears only the valid bit; the word registers keep their contents.
module pipe_reg_stage
   import pipe_reg_pkg::*;
#(
   parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           adv_in,
   input  logic           flush,
   input  logic           up_valid_i,
   input  logic [WIDTH:0] up_word_i,
   output logic           valid_o,
   output logic [WIDTH:0] word_o
);

   logic           valid_q, valid_d;
   logic [WIDTH:0] word_q,  word_d;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (adv_in) begin
         valid_d = up_valid_i;
         word_d  = up_word_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic chain of STAGES registers with valid/ready, global load enable and flush.
// Define PIPE_REG_COUNT_EN to add the registered occupancy output 'count'.
module pipe_reg_chain
   import pipe_reg_pkg::*;
#(
   parameter int WIDTH  = PIPE_WIDTH_DEFAULT,
   parameter int STAGES = PIPE_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_flag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_flag
`ifdef PIPE_REG_COUNT_EN
   ,
   output logic [cnt_w(STAGES)-1:0] count
`endif
);

   typedef struct packed {
      logic             flag;
      logic [WIDTH-1:0] data;
   } word_t;

   logic [STAGES:0]   adv;
   logic [STAGES-1:0] stageValid;
   word_t             stageWord [STAGES];
   word_t             inWord;

   assign inWord = '{flag: in_flag, data: in_data};

   // Ready ripples from the output back toward the input so bubbles collapse.
   always_comb begin
      adv         = '0;
      adv[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv[i] = ld & ~flush & (~stageValid[i] | adv[i+1]);
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : gStage
      logic  upValid;
      word_t upWord;

      if (g == 0) begin : gHead
         assign upValid = in_valid;
         assign upWord  = inWord;
      end else begin : gBody
         assign upValid = stageValid[g-1];
         assign upWord  = stageWord[g-1];
      end

      pipe_reg_stage #(
         .WIDTH(WIDTH)
      ) uStage (
         .clk       (clk),
         .rst       (rst),
         .adv_in    (adv[g]),
         .flush     (flush),
         .up_valid_i(upValid),
         .up_word_i (upWord),
         .valid_o   (stageValid[g]),
         .word_o    (stageWord[g])
      );
   end

   assign in_ready  = adv[0];
   assign out_valid = stageValid[STAGES-1];
   assign out_data  = stageWord[STAGES-1].data;
   assign out_flag  = stageWord[STAGES-1].flag;

`ifdef PIPE_REG_COUNT_EN
   localparam int CW = cnt_w(STAGES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept, retire;

   assign accept = in_valid & adv[0];
   assign retire = out_valid & out_ready & ld & ~flush;

   // Up/down tracking of occupancy; simultaneous accept and retire cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else if (accept & ~retire) begin
         cnt_d = cnt_q + CW'(1);
      end else if (retire & ~accept) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
`endif

endmodule
